// File: rtl/auto_player_pkg.sv
// auto_player shared types: FSM states, button select, parameter defaults.
// Optional restart loop is enabled by defining AUTO_PLAYER_RESTART_EN.
package auto_player_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    REACT,
    PRESS,
    OVER
  } state_e;

  typedef enum logic [1:0] {
    BTN_NONE,
    BTN_A,
    BTN_B
  } btn_e;

  localparam int DEF_REACT_CYCLES   = 8;
  localparam int DEF_PRESS_CYCLES   = 4;
  localparam int DEF_RESTART_CYCLES = 16;
  localparam int DEF_CNT_W          = 8;
  localparam int PRESSES_W          = 8;

endpackage

// File: rtl/auto_player_timer.sv
// Shared down-counter: load a value, done when it reaches zero.
// One timer serves the start, react, press and restart durations.
module auto_player_timer
  import auto_player_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/auto_player.sv
// Self-play driver for the LED reaction game (demo mode).
// Define AUTO_PLAYER_RESTART_EN to loop back to START after game-over.
module auto_player
  import auto_player_pkg::*;
#(
  parameter int REACT_CYCLES   = DEF_REACT_CYCLES,
  parameter int PRESS_CYCLES   = DEF_PRESS_CYCLES,
  parameter int RESTART_CYCLES = DEF_RESTART_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       LedVerde,
  input  logic       LedRED,
  input  logic       LedFin,
  output logic       Start,
  output logic       BotonA,
  output logic       BotonB,
  output logic [7:0] Presses
);

  // Timer counts load_val..0, so a duration of D loads D-1.
  localparam logic [CNT_W-1:0] REACT_LD   = CNT_W'(REACT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRESS_LD   = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESTART_LD = CNT_W'(RESTART_CYCLES - 1);

  state_e state_q, state_d;
  btn_e   sel_q, sel_d;

  logic en_q;
  logic v_q, r_q, f_q;
  logic vd_q, rd_q;

  logic start_q, start_d;
  logic btn_a_q, btn_a_d;
  logic btn_b_q, btn_b_d;

  logic [PRESSES_W-1:0] presses_q, presses_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  logic prompt_v;
  logic prompt_r;

  assign prompt_v = v_q & ~vd_q;
  assign prompt_r = r_q & ~rd_q;

  auto_player_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clock),
    .rst     (Reset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done    (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    presses_d = presses_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    if (!en_q) begin
      state_d = IDLE;
      sel_d   = BTN_NONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d  = START;
          tmr_load = 1'b1;
          tmr_val  = PRESS_LD;
        end
        START: begin
          if (tmr_done) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (f_q) begin
            state_d  = OVER;
            tmr_load = 1'b1;
            tmr_val  = RESTART_LD;
          end else if (prompt_v ^ prompt_r) begin
            state_d  = REACT;
            sel_d    = prompt_v ? BTN_A : BTN_B;
            tmr_load = 1'b1;
            tmr_val  = REACT_LD;
          end
        end
        REACT: begin
          if (f_q) begin
            state_d  = OVER;
            sel_d    = BTN_NONE;
            tmr_load = 1'b1;
            tmr_val  = RESTART_LD;
          end else if (tmr_done) begin
            state_d  = PRESS;
            tmr_load = 1'b1;
            tmr_val  = PRESS_LD;
          end
        end
        PRESS: begin
          if (f_q) begin
            state_d  = OVER;
            sel_d    = BTN_NONE;
            tmr_load = 1'b1;
            tmr_val  = RESTART_LD;
          end else if (tmr_done) begin
            state_d = WAIT;
            sel_d   = BTN_NONE;
            if (presses_q != '1) begin
              presses_d = presses_q + 1'b1;
            end
          end
        end
        OVER: begin
`ifdef AUTO_PLAYER_RESTART_EN
          if (tmr_done) begin
            state_d  = START;
            tmr_load = 1'b1;
            tmr_val  = PRESS_LD;
          end
`else
          state_d = OVER;
`endif
        end
        default: begin
          state_d = IDLE;
          sel_d   = BTN_NONE;
        end
      endcase
    end

    // Outputs follow the next state so they line up with it.
    start_d = (state_d == START);
    btn_a_d = (state_d == PRESS) && (sel_d == BTN_A);
    btn_b_d = (state_d == PRESS) && (sel_d == BTN_B);
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      sel_q     <= BTN_NONE;
      en_q      <= 1'b0;
      v_q       <= 1'b0;
      r_q       <= 1'b0;
      f_q       <= 1'b0;
      vd_q      <= 1'b0;
      rd_q      <= 1'b0;
      start_q   <= 1'b0;
      btn_a_q   <= 1'b0;
      btn_b_q   <= 1'b0;
      presses_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      en_q      <= Enable;
      v_q       <= LedVerde;
      r_q       <= LedRED;
      f_q       <= LedFin;
      vd_q      <= v_q;
      rd_q      <= r_q;
      start_q   <= start_d;
      btn_a_q   <= btn_a_d;
      btn_b_q   <= btn_b_d;
      presses_q <= presses_d;
    end
  end

  assign Start   = start_q;
  assign BotonA  = btn_a_q;
  assign BotonB  = btn_b_q;
  assign Presses = presses_q;

endmodule

// File: tb/tb_auto_player.sv
// Bench for auto_player: timeline reference model plus directed scenarios.
// Follows AUTO_PLAYER_RESTART_EN when the same define is given.
module tb_auto_player;

  localparam int R  = 8;
  localparam int P  = 4;
  localparam int RS = 16;

`ifdef AUTO_PLAYER_RESTART_EN
  localparam bit RESTART_EN = 1'b1;
`else
  localparam bit RESTART_EN = 1'b0;
`endif

  logic       clock    = 1'b0;
  logic       Reset    = 1'b1;
  logic       Enable   = 1'b0;
  logic       LedVerde = 1'b0;
  logic       LedRED   = 1'b0;
  logic       LedFin   = 1'b0;
  logic       Start;
  logic       BotonA;
  logic       BotonB;
  logic [7:0] Presses;

  auto_player #(
    .REACT_CYCLES  (R),
    .PRESS_CYCLES  (P),
    .RESTART_CYCLES(RS),
    .CNT_W         (8)
  ) dut (
    .clock   (clock),
    .Reset   (Reset),
    .Enable  (Enable),
    .LedVerde(LedVerde),
    .LedRED  (LedRED),
    .LedFin  (LedFin),
    .Start   (Start),
    .BotonA  (BotonA),
    .BotonB  (BotonB),
    .Presses (Presses)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  int t      = 0;

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s t=%0d got %0d expected %0d", tag, t, got, exp);
  endtask

  // Reference model: registered LED/enable copies and timeline windows.
  bit m_en = 0, m_v1 = 0, m_v2 = 0, m_r1 = 0, m_r2 = 0, m_f = 0;
  bit m_idle = 1, m_over = 0, m_pend = 0;
  int s0 = 1, s1 = 0;
  int b0 = 1, b1 = 0;
  int m_btn = 0;
  int wait_from = 0;
  int pend_end = 0;
  int restart_at = 0;
  int m_presses = 0;

  task automatic model_reset();
    m_en = 0; m_v1 = 0; m_v2 = 0; m_r1 = 0; m_r2 = 0; m_f = 0;
    m_idle = 1; m_over = 0; m_pend = 0;
    s0 = 1; s1 = 0; b0 = 1; b1 = 0; m_btn = 0;
    m_presses = 0;
  endtask

  task automatic begin_start();
    s0 = t;
    s1 = t + P - 1;
    wait_from = t + P + 1;
  endtask

  task automatic model_edge();
    bit pv, pr;
    pv = m_v1 & ~m_v2;
    pr = m_r1 & ~m_r2;
    if (!m_en) begin
      m_idle = 1; m_over = 0; m_pend = 0;
      if (s1 >= t) s1 = t - 1;
      if (b1 >= t) b1 = t - 1;
    end else if (m_idle) begin
      m_idle = 0;
      begin_start();
    end else if (m_over) begin
      if (RESTART_EN && t == restart_at) begin
        m_over = 0;
        begin_start();
      end
    end else if (t >= wait_from) begin
      if (m_f) begin
        m_over = 1;
        restart_at = t + RS;
        if (b1 >= t) b1 = t - 1;
        m_pend = 0;
      end else if (m_pend) begin
        if (t == pend_end) begin
          m_pend = 0;
          if (m_presses < 255) m_presses++;
        end
      end else if (pv ^ pr) begin
        m_pend = 1;
        m_btn = pv ? 1 : 2;
        b0 = t + R;
        b1 = t + R + P - 1;
        pend_end = t + R + P;
      end
    end
    m_en = Enable;
    m_v2 = m_v1; m_v1 = LedVerde;
    m_r2 = m_r1; m_r1 = LedRED;
    m_f  = LedFin;
  endtask

  always @(posedge clock or posedge Reset) begin
    if (Reset) model_reset();
    else begin
      t++;
      model_edge();
    end
  end

  always @(negedge clock) begin
    check("m_start", int'(Start), int'(t >= s0 && t <= s1));
    check("m_a", int'(BotonA), int'(m_btn == 1 && t >= b0 && t <= b1));
    check("m_b", int'(BotonB), int'(m_btn == 2 && t >= b0 && t <= b1));
    check("m_presses", int'(Presses), m_presses);
    check("onehot", int'(Start) + int'(BotonA) + int'(BotonB) <= 1 ? 1 : 0, 1);
  end

  task automatic tick();
    @(negedge clock);
  endtask

  initial begin
    int n;
    int p0;
    int k;

    #1;
    check("rst_start", int'(Start), 0);
    check("rst_a", int'(BotonA), 0);
    check("rst_b", int'(BotonB), 0);
    check("rst_presses", int'(Presses), 0);
    repeat (3) tick();
    Reset = 1'b0;
    repeat (3) tick();

    // Start pulse after Enable
    Enable = 1'b1;
    n = t + 1;
    repeat (P + 3) begin
      tick();
      check("dir_start", int'(Start), int'(t >= n + 1 && t <= n + P));
    end
    repeat (5) tick();

    // Green prompt -> BotonA pulse, one press
    LedVerde = 1'b1;
    n = t + 1;
    repeat (R + P + 4) begin
      tick();
      check("dir_a", int'(BotonA), int'(t >= n + R + 1 && t <= n + R + P));
      check("dir_cnt", int'(Presses), (t >= n + R + P + 1) ? 1 : 0);
    end
    LedVerde = 1'b0;
    repeat (2) tick();

    // Simultaneous edges are ignored
    p0 = m_presses;
    LedVerde = 1'b1;
    LedRED = 1'b1;
    repeat (20) begin
      tick();
      check("both_a", int'(BotonA), 0);
      check("both_b", int'(BotonB), 0);
      check("both_cnt", int'(Presses), p0);
    end
    LedVerde = 1'b0;
    LedRED = 1'b0;
    repeat (2) tick();
    LedRED = 1'b1;
    n = t + 1;
    repeat (R + P + 4) begin
      tick();
      check("dir_b", int'(BotonB), int'(t >= n + R + 1 && t <= n + R + P));
    end
    LedRED = 1'b0;
    check("dir_b_cnt", int'(Presses), p0 + 1);
    repeat (3) tick();

    // Reset in the middle of a press
    LedVerde = 1'b1;
    tick();
    LedVerde = 1'b0;
    k = 0;
    while (!BotonA && k < 30) begin
      tick();
      k++;
    end
    check("rst_wait_a", int'(BotonA), 1);
    #2 Reset = 1'b1;
    #1;
    check("mid_rst_start", int'(Start), 0);
    check("mid_rst_a", int'(BotonA), 0);
    check("mid_rst_b", int'(BotonB), 0);
    check("mid_rst_cnt", int'(Presses), 0);
    repeat (2) tick();
    Reset = 1'b0;
    repeat (30) begin
      tick();
      check("rst_no_a", int'(BotonA), 0);
      check("rst_cnt0", int'(Presses), 0);
    end

    // Game-over during a BotonB press
    LedRED = 1'b1;
    tick();
    LedRED = 1'b0;
    k = 0;
    while (!BotonB && k < 30) begin
      tick();
      k++;
    end
    check("fin_wait_b", int'(BotonB), 1);
    p0 = m_presses;
    tick();
    LedFin = 1'b1;
    n = t + 1;
    tick();
    check("fin_b_hold", int'(BotonB), 1);
    tick();
    check("fin_b_low", int'(BotonB), 0);
    while (t < n + RS + 2) begin
      tick();
      if (t == n + 3) LedFin = 1'b0;
      check("fin_cnt", int'(Presses), p0);
      if (t == n + 1 + RS) check("fin_restart", int'(Start), int'(RESTART_EN));
    end
    LedFin = 1'b0;
    repeat (10) tick();
    Enable = 1'b0;
    repeat (3) tick();
    check("dis_start", int'(Start), 0);
    check("dis_a", int'(BotonA), 0);
    check("dis_b", int'(BotonB), 0);
    check("dis_keep", int'(Presses), p0);
    Enable = 1'b1;
    repeat (12) tick();

    // Second prompt 3 cycles after first: one press
    p0 = m_presses;
    LedVerde = 1'b1;
    tick();
    LedVerde = 1'b0;
    tick();
    tick();
    LedVerde = 1'b1;
    tick();
    LedVerde = 1'b0;
    repeat (25) tick();
    check("dbl", int'(Presses), p0 + 1);

    // Random traffic against the model
    repeat (1500) begin
      if ($urandom % 5 == 0) LedVerde = ~LedVerde;
      if ($urandom % 5 == 0) LedRED = ~LedRED;
      if ($urandom % 120 == 0) LedFin = ~LedFin;
      if ($urandom % 400 == 0) Enable = ~Enable;
      tick();
    end

    // Saturation
    LedVerde = 1'b0;
    LedRED = 1'b0;
    LedFin = 1'b0;
    Enable = 1'b0;
    repeat (3) tick();
    Enable = 1'b1;
    repeat (12) tick();
    repeat (300) begin
      if ($urandom % 2 == 1) LedVerde = 1'b1;
      else LedRED = 1'b1;
      tick();
      LedVerde = 1'b0;
      LedRED = 1'b0;
      repeat (R + P + 3) tick();
    end
    repeat (5) tick();
    check("sat", int'(Presses), 255);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
